chip8_loader: RTL and testbench

- Writer side of the CHIP-8 program RAM.
- Receives a framed program image as a byte stream from the UART receiver and drives the RAM write port (we/waddr/d), starting at the CHIP-8 program base.
- Returns a one-byte ACK/NAK to the UART transmitter through a valid/ready handshake.
- Sits in top between the uart rx/tx blocks and the ram write port.

---
 rtl/chip8_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_chip8_loader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_loader.sv
// -----------------------------------------------------------------------------
// chip8_loader
//   Writer side of the CHIP-8 program RAM. Takes a framed program image from
//   the UART receiver, writes it to RAM starting at LOAD_BASE, and answers with
//   a one-byte ACK (0x06) or NAK (0x15) to the UART transmitter.
//
//   Frame: 0x4C ('L'), LEN_HI, LEN_LO, LEN data bytes [, checksum byte]
//
//   Optional feature macro: CHIP8_LOADER_CSUM_EN
//     When defined, a trailing checksum byte (sum of data bytes mod 256)
//     follows the data. A mismatch is answered with NAK.
//
// Ports
//   ice_clk_i    system clock
//   rstn_i       asynchronous active-low reset
//   rx_data_i    received byte, valid with rx_valid_i
//   rx_valid_i   single-cycle strobe per received byte
//   tx_data_o    response byte (ACK/NAK)
//   tx_valid_o   response valid, held until tx_ready_i
//   tx_ready_i   transmitter accepts tx_data_o
//   ram_we_o     RAM write enable, one-cycle pulse
//   ram_waddr_o  RAM write address
//   ram_d_o      RAM write data
//   busy_o       frame in progress
//   done_o       sticky: last frame completed OK
//   err_o        sticky: last frame failed
//
// State table
//   state      | meaning
//   ST_IDLE    | waiting for the 0x4C start byte
//   ST_LEN_HI  | waiting for the upper length byte
//   ST_LEN_LO  | waiting for the lower length byte, length check
//   ST_DATA    | writing data bytes to RAM
//   ST_CSUM    | waiting for the checksum byte (checksum build only)
//   ST_RESP    | presenting ACK/NAK until the transmitter takes it
// -----------------------------------------------------------------------------
module chip8_loader #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned LOAD_BASE      = 12'h200,
    parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
    input  logic                  ice_clk_i,
    input  logic                  rstn_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic [7:0]            ram_d_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [7:0] SOF_BYTE = 8'h4C;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam int unsigned MAX_LEN = (1 << ADDR_WIDTH) - LOAD_BASE;
    localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(LOAD_BASE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_RESP
`ifdef CHIP8_LOADER_CSUM_EN
        , ST_CSUM
`endif
    } state_t;

    state_t                  state;
    logic [7:0]              len_hi;
    logic [15:0]             remain;
    logic [ADDR_WIDTH-1:0]   wptr;
    logic [TW-1:0]           tmo_cnt;
`ifdef CHIP8_LOADER_CSUM_EN
    logic [7:0]              csum;
`endif

    logic [15:0] len_rx;
    logic        tmo_active;
    logic        timed_out;
    logic        go_resp;
    logic        resp_ack;

    assign len_rx = {len_hi, rx_data_i};
    assign busy_o = (state != ST_IDLE);

    // Idle-gap timer only runs while a frame is being received.
    assign tmo_active = (state != ST_IDLE) && (state != ST_RESP);
    // A byte arriving in the firing cycle cancels the timeout.
    assign timed_out  = tmo_active && !rx_valid_i && (tmo_cnt == '0);

    // Decode every way of ending a frame in one place.
    always_comb begin
        go_resp  = 1'b0;
        resp_ack = 1'b0;
        case (state)
            ST_LEN_LO: begin
                if (rx_valid_i) begin
                    if ({16'd0, len_rx} > MAX_LEN) begin
                        go_resp = 1'b1;
                    end
`ifndef CHIP8_LOADER_CSUM_EN
                    else if (len_rx == 16'd0) begin
                        go_resp  = 1'b1;
                        resp_ack = 1'b1;
                    end
`endif
                end
            end
`ifndef CHIP8_LOADER_CSUM_EN
            ST_DATA: begin
                if (rx_valid_i && remain == 16'd1) begin
                    go_resp  = 1'b1;
                    resp_ack = 1'b1;
                end
            end
`else
            ST_CSUM: begin
                if (rx_valid_i) begin
                    go_resp  = 1'b1;
                    resp_ack = (rx_data_i == csum);
                end
            end
`endif
            default: ;
        endcase
        if (timed_out) begin
            go_resp  = 1'b1;
            resp_ack = 1'b0;
        end
    end

    always_ff @(posedge ice_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= ST_IDLE;
            len_hi      <= '0;
            remain      <= '0;
            wptr        <= '0;
            tmo_cnt     <= '0;
`ifdef CHIP8_LOADER_CSUM_EN
            csum        <= '0;
`endif
            tx_data_o   <= '0;
            tx_valid_o  <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_waddr_o <= '0;
            ram_d_o     <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            ram_we_o <= 1'b0;

            if (rx_valid_i) begin
                tmo_cnt <= TMO_LOAD;
            end else if (tmo_active && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_valid_i && rx_data_i == SOF_BYTE) begin
                        state  <= ST_LEN_HI;
                        done_o <= 1'b0;
                        err_o  <= 1'b0;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_valid_i) begin
                        len_hi <= rx_data_i;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (rx_valid_i) begin
                        remain <= len_rx;
                        wptr   <= BASE_ADDR;
`ifdef CHIP8_LOADER_CSUM_EN
                        csum   <= '0;
                        state  <= (len_rx == 16'd0) ? ST_CSUM : ST_DATA;
`else
                        state  <= ST_DATA;
`endif
                    end
                end
                ST_DATA: begin
                    if (rx_valid_i) begin
                        ram_we_o    <= 1'b1;
                        ram_waddr_o <= wptr;
                        ram_d_o     <= rx_data_i;
                        wptr        <= wptr + 1'b1;
                        remain      <= remain - 16'd1;
`ifdef CHIP8_LOADER_CSUM_EN
                        csum        <= csum + rx_data_i;
                        if (remain == 16'd1) begin
                            state <= ST_CSUM;
                        end
`endif
                    end
                end
                ST_RESP: begin
                    if (tx_ready_i) begin
                        tx_valid_o <= 1'b0;
                        tx_data_o  <= '0;
                        state      <= ST_IDLE;
                    end
                end
                default: ;
            endcase

            // Overrides the state update above when the frame ends this cycle.
            if (go_resp) begin
                state      <= ST_RESP;
                tx_valid_o <= 1'b1;
                tx_data_o  <= resp_ack ? ACK_BYTE : NAK_BYTE;
                done_o     <= resp_ack;
                err_o      <= !resp_ack;
            end
        end
    end

endmodule

// File: tb/tb_chip8_loader.sv
module tb_chip8_loader;

    localparam int AW      = 12;
    localparam int BASE    = 12'h200;
    localparam int TMO     = 300;
    localparam int MAXLEN  = (1 << AW) - BASE;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
`ifdef CHIP8_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data_o;
    logic          tx_valid_o;
    logic          tx_ready;
    logic          ram_we_o;
    logic [AW-1:0] ram_waddr_o;
    logic [7:0]    ram_d_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    always #5 clk = ~clk;

    chip8_loader #(
        .ADDR_WIDTH    (AW),
        .LOAD_BASE     (BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ice_clk_i  (clk),
        .rstn_i     (rstn),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready),
        .ram_we_o   (ram_we_o),
        .ram_waddr_o(ram_waddr_o),
        .ram_d_o    (ram_d_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0]   wq[$];
    logic [AW-1:0] last_waddr;
    logic [7:0]    dat[0:4095];

    always @(negedge clk) begin
        if (rstn && ram_we_o) begin
            wq.push_back({ram_waddr_o, ram_d_o});
            last_waddr = ram_waddr_o;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Reference: response for a frame of length len with (bad) checksum.
    function automatic logic [7:0] model_resp(input int len, input bit bad);
        if (len > MAXLEN) return NAK;
        return (CSUM_ON && bad) ? NAK : ACK;
    endfunction

    function automatic int model_writes(input int len);
        return (len > MAXLEN) ? 0 : len;
    endfunction

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo,
                              input int ndata, input bit bad, input bit gaps);
        logic [7:0] s;
        logic [7:0] cs;
        int         len;
        s   = 8'h00;
        len = int'({hi, lo});
        wq.delete();
        send_byte(8'h4C);
        send_byte(hi);
        send_byte(lo);
        for (int i = 0; i < ndata; i++) begin
            dat[i] = 8'($urandom);
            s      = s + dat[i];
            if (gaps) tick($urandom_range(0, 3));
            send_byte(dat[i]);
        end
        if (CSUM_ON && len <= MAXLEN) begin
            cs = bad ? s + 8'd1 : s;
            send_byte(cs);
        end
    endtask

    task automatic expect_resp(input string name, input logic [7:0] exp, input int budget);
        int w;
        w = 0;
        while (!tx_valid_o && w < budget) begin
            tick(1);
            w++;
        end
        check({name, "_tx_valid"}, {31'd0, tx_valid_o}, 32'd1);
        check({name, "_tx_data"}, {24'd0, tx_data_o}, {24'd0, exp});
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        check({name, "_after_ready"}, {22'd0, tx_valid_o, tx_data_o, busy_o},
              32'd0);
        check({name, "_done_err"}, {30'd0, done_o, err_o},
              {30'd0, (exp == ACK), (exp == NAK)});
    endtask

    task automatic check_writes(input string name, input int n);
        int bad;
        bad = 0;
        check({name, "_nwrites"}, wq.size(), n);
        for (int i = 0; i < wq.size() && i < n; i++) begin
            if (wq[i] !== {12'(BASE + i), dat[i]}) bad++;
        end
        check({name, "_content"}, bad, 0);
        wq.delete();
    endtask

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        int         ndata;
        logic [7:0] resp;
        int         nwr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         stable_bad;
        int         len;
        int         nd;
        bit         bad;
        logic [7:0] noise;
        logic [7:0] lh;
        logic [7:0] ll;

        tbl[0] = '{8'h00, 8'h03,    3, ACK,    3};
        tbl[1] = '{8'h0E, 8'h01,    0, NAK,    0};
        tbl[2] = '{8'h00, 8'h00,    0, ACK,    0};
        tbl[3] = '{8'h0E, 8'h00, 3584, ACK, 3584};
        tbl[4] = '{8'h00, 8'h01,    1, ACK,    1};
        tbl[5] = '{8'h10, 8'h00,    0, NAK,    0};
        tbl[6] = '{8'hFF, 8'hFF,    0, NAK,    0};
        tbl[7] = '{8'h01, 8'h00,  256, ACK,  256};

        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        tick(3);
        check("reset_outputs",
              {9'd0, tx_data_o, tx_valid_o, ram_we_o, ram_waddr_o, ram_d_o, busy_o, done_o, err_o},
              32'd0);
        rstn = 1'b1;
        tick(2);
        check("idle_after_reset", {29'd0, busy_o, done_o, err_o}, 32'd0);

        // Write latency and hold of address/data between writes.
        wq.delete();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h03);
        dat[0] = 8'hAA; dat[1] = 8'hBB; dat[2] = 8'hCC;
        for (int i = 0; i < 3; i++) begin
            send_byte(dat[i]);
            check("lat_write", {11'd0, ram_we_o, ram_waddr_o, ram_d_o},
                  {11'd0, 1'b1, 12'(BASE + i), dat[i]});
            tick(1);
            check("lat_hold", {11'd0, ram_we_o, ram_waddr_o, ram_d_o},
                  {11'd0, 1'b0, 12'(BASE + i), dat[i]});
        end
        if (CSUM_ON) send_byte(8'h31);
        expect_resp("lat", ACK, 20);
        check_writes("lat", 3);

        // Table of frames, each preceded by a stray byte that must be ignored.
        for (int v = 0; v < 8; v++) begin
            noise = 8'($urandom);
            if (noise == 8'h4C) noise = 8'h00;
            send_byte(noise);
            tick(2);
            check("noise_ignored", {31'd0, busy_o}, 32'd0);
            send_frame(tbl[v].hi, tbl[v].lo, tbl[v].ndata, 1'b0, 1'b0);
            expect_resp("tbl", tbl[v].resp, 20);
            if (v == 3) check("last_addr_fff", {20'd0, last_waddr}, 32'hFFF);
            check_writes("tbl", tbl[v].nwr);
        end

        // Timeout after partial data.
        wq.delete();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h04);
        dat[0] = 8'h11; dat[1] = 8'h22;
        send_byte(8'h11);
        send_byte(8'h22);
        tick(TMO - 5);
        check("tmo_not_early", {30'd0, busy_o, tx_valid_o}, {30'd0, 2'b10});
        expect_resp("tmo", NAK, 30);
        check_writes("tmo", 2);

        // Byte arriving exactly in the timeout cycle wins.
        wq.delete();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h02);
        dat[0] = 8'($urandom);
        dat[1] = 8'($urandom);
        send_byte(dat[0]);
        tick(TMO - 1);
        send_byte(dat[1]);
        if (CSUM_ON) send_byte(dat[0] + dat[1]);
        expect_resp("tmo_edge", ACK, 20);
        check_writes("tmo_edge", 2);

        // Response held while the transmitter stalls; rx bytes are dropped.
        send_frame(8'h00, 8'h01, 1, 1'b0, 1'b0);
        for (int w = 0; w < 20 && !tx_valid_o; w++) tick(1);
        stable_bad = 0;
        for (int i = 0; i < 50; i++) begin
            send_byte((i % 3 == 0) ? 8'h4C : 8'($urandom));
            if (!(tx_valid_o && tx_data_o == ACK && busy_o)) stable_bad++;
        end
        check("hold_stable", stable_bad, 0);
        expect_resp("hold", ACK, 5);
        check_writes("hold", 1);

`ifdef CHIP8_LOADER_CSUM_EN
        foreach (dat[i]) dat[i] = 8'h00;
        dat[0] = 8'h01; dat[1] = 8'h02;
        wq.delete();
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04);
        expect_resp("csum_bad", NAK, 20);
        check_writes("csum_bad", 2);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        expect_resp("csum_good", ACK, 20);
        check_writes("csum_good", 2);
`endif

        // Reset in the middle of DATA.
        wq.delete();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h5A);
        send_byte(8'hA5);
        rstn = 1'b0;
        #1;
        check("reset_mid",
              {9'd0, tx_data_o, tx_valid_o, ram_we_o, ram_waddr_o, ram_d_o, busy_o, done_o, err_o},
              32'd0);
        tick(1);
        rstn = 1'b1;
        tick(1);
        send_frame(8'h00, 8'h01, 1, 1'b0, 1'b0);
        expect_resp("post_reset", ACK, 20);
        check_writes("post_reset", 1);

        // Randomized frames against the reference model.
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                len = $urandom_range(MAXLEN + 1, 65535);
                nd  = 0;
            end else begin
                len = $urandom_range(0, 60);
                nd  = len;
            end
            bad = CSUM_ON && ($urandom_range(0, 3) == 0);
            lh  = 8'(len >> 8);
            ll  = 8'(len);
            send_frame(lh, ll, nd, bad, 1'b1);
            expect_resp("rand", model_resp(len, bad), 30);
            check_writes("rand", model_writes(len));
            tick($urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
